accel_sample_frontend: RTL and testbench

//  Upstream conditioning stage for the pedometer core. Accepts raw 8-bit accelerometer magnitude

---
 rtl/accel_sample_frontend_if.sv | 25 ++
 rtl/accel_sample_frontend.sv | 171 +++++++++++++++++
 tb/tb_accel_sample_frontend.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/accel_sample_frontend_if.sv
// Sample-in / filtered-pair-out signal bundle for accel_sample_frontend.
// master = sample producer and pedometer core side, slave = the frontend.
interface accel_sample_frontend_if #(
    parameter int DATA_W    = 8,
    parameter int FIFO_LOG2 = 2
);
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic              out_ready;
    logic              countSteps;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic [FIFO_LOG2:0] fill_level;

    modport master (
        output s_valid, s_data, out_ready,
        input  s_ready, countSteps, A, B, fill_level
    );

    modport slave (
        input  s_valid, s_data, out_ready,
        output s_ready, countSteps, A, B, fill_level
    );
endinterface

// File: rtl/accel_sample_frontend.sv
// Raw accelerometer sample FIFO, moving-average filter and (current, previous)
// pair emitter feeding the pedometer core.
module accel_sample_frontend #(
    parameter int DATA_W    = 8,
    parameter int WIN_LOG2  = 2,
    parameter int FIFO_LOG2 = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    accel_sample_frontend_if.slave bus
);
    localparam int unsigned WIN   = 1 << WIN_LOG2;
    localparam int unsigned DEPTH = 1 << FIFO_LOG2;
    localparam int unsigned SUM_W = DATA_W + WIN_LOG2;

    localparam logic [FIFO_LOG2:0]  FULL_LVL = {1'b1, {FIFO_LOG2{1'b0}}};
    localparam logic [WIN_LOG2-1:0] LAST_TAP = '1;

    typedef enum logic [1:0] {ST_FILL, ST_RUN, ST_EMIT} state_t;

    logic [DATA_W-1:0]    mem_q [DEPTH];
    logic [DATA_W-1:0]    mem_d [DEPTH];
    logic [FIFO_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_LOG2:0]   cnt_q, cnt_d;

    logic [DATA_W-1:0]    taps_q [WIN];
    logic [DATA_W-1:0]    taps_d [WIN];
    logic [SUM_W-1:0]     sum_q, sum_d;
    logic [WIN_LOG2-1:0]  tap_cnt_q, tap_cnt_d;
    logic [DATA_W-1:0]    prev_q, prev_d;
    logic [DATA_W-1:0]    a_q, a_d;
    logic [DATA_W-1:0]    b_q, b_d;
    state_t               state_q, state_d;

    logic              fifo_full;
    logic              fifo_empty;
    logic              s_ready;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head;
    logic [SUM_W-1:0]  sum_n;
    logic [DATA_W-1:0] filt;

    assign fifo_full  = (cnt_q == FULL_LVL);
    assign fifo_empty = (cnt_q == '0);
    // Readiness uses the pre-pop level, so a full FIFO refuses even when popping.
    assign s_ready    = !fifo_full && !flush;
    assign push       = bus.s_valid && s_ready;
    assign pop        = (state_q != ST_EMIT) && !fifo_empty && !flush;
    assign head       = mem_q[rd_ptr_q];

    // Oldest tap is always part of sum, so this never underflows.
    assign sum_n = sum_q + SUM_W'(head) - SUM_W'(taps_q[WIN-1]);
    assign filt  = sum_n[SUM_W-1:WIN_LOG2];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = bus.s_data;
                wr_ptr_d        = wr_ptr_q + FIFO_LOG2'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + FIFO_LOG2'(1);
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + (FIFO_LOG2+1)'(1);
                2'b01:   cnt_d = cnt_q - (FIFO_LOG2+1)'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        taps_d    = taps_q;
        sum_d     = sum_q;
        tap_cnt_d = tap_cnt_q;
        prev_d    = prev_q;
        a_d       = a_q;
        b_d       = b_q;
        if (flush) begin
            state_d   = ST_FILL;
            taps_d    = '{default: '0};
            sum_d     = '0;
            tap_cnt_d = '0;
            prev_d    = '0;
            a_d       = '0;
            b_d       = '0;
        end else begin
            if (pop) begin
                taps_d[0] = head;
                for (int unsigned i = 1; i < WIN; i++) begin
                    taps_d[i] = taps_q[i-1];
                end
                sum_d = sum_n;
            end
            case (state_q)
                ST_FILL: begin
                    if (pop) begin
                        if (tap_cnt_q == LAST_TAP) begin
                            a_d     = filt;
                            b_d     = filt;
                            prev_d  = filt;
                            state_d = ST_EMIT;
                        end else begin
                            tap_cnt_d = tap_cnt_q + WIN_LOG2'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (pop) begin
                        a_d     = filt;
                        b_d     = prev_q;
                        prev_d  = filt;
                        state_d = ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (bus.out_ready) begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_FILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q     <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            taps_q    <= '{default: '0};
            sum_q     <= '0;
            tap_cnt_q <= '0;
            prev_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            state_q   <= ST_FILL;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            taps_q    <= taps_d;
            sum_q     <= sum_d;
            tap_cnt_q <= tap_cnt_d;
            prev_q    <= prev_d;
            a_q       <= a_d;
            b_q       <= b_d;
            state_q   <= state_d;
        end
    end

    assign bus.s_ready    = s_ready;
    assign bus.countSteps = (state_q == ST_EMIT);
    assign bus.A          = a_q;
    assign bus.B          = b_q;
    assign bus.fill_level = cnt_q;
endmodule

// File: tb/tb_accel_sample_frontend.sv
// Bench for accel_sample_frontend: directed scenarios plus randomized traffic
// checked against a sample-history moving-average reference.
module tb_accel_sample_frontend;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    accel_sample_frontend_if #(.DATA_W(8), .FIFO_LOG2(2)) bus ();

    accel_sample_frontend #(.DATA_W(8), .WIN_LOG2(2), .FIFO_LOG2(2)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        integer     ea;
        integer     eb;
    } xfer_t;

    xfer_t got_q[$];
    int    hist[$];
    int    n_xfer = 0;
    int    errors = 0;
    int    checks = 0;

    // Reference: transfer j pairs avg(samples j..j+3) with avg(samples j-1..j+2).
    function automatic integer avg4(input int j);
        if (j < 0 || j + 3 >= hist.size()) return -1;
        return (hist[j] + hist[j+1] + hist[j+2] + hist[j+3]) / 4;
    endfunction

    always @(negedge clk) begin
        xfer_t x;
        if (!reset || flush) begin
            hist.delete();
            n_xfer = 0;
        end else begin
            if (bus.countSteps && bus.out_ready) begin
                x.a  = bus.A;
                x.b  = bus.B;
                x.ea = avg4(n_xfer);
                x.eb = (n_xfer == 0) ? x.ea : avg4(n_xfer - 1);
                got_q.push_back(x);
                n_xfer++;
            end
            if (bus.s_valid && bus.s_ready) hist.push_back(int'(bus.s_data));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        logic acc;
        int   n;
        acc = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = v;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            acc = bus.s_ready;
            step();
            if (acc) break;
        end
        bus.s_valid = 1'b0;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL push_timeout: s_ready=%0b after %0d cycles, expected 1", acc, n);
        end
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            step();
            if (bus.fill_level == 0 && !bus.countSteps) done = 1'b1;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL drain_timeout: fill_level=%0d countSteps=%0b, expected 0/0", bus.fill_level, bus.countSteps);
        end
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (bus.countSteps !== 1'b0) begin errors++; $display("FAIL rst_cs: got %0b expected 0", bus.countSteps); end
        checks++; if (bus.A !== 8'd0) begin errors++; $display("FAIL rst_A: got %0d expected 0", bus.A); end
        checks++; if (bus.B !== 8'd0) begin errors++; $display("FAIL rst_B: got %0d expected 0", bus.B); end
        checks++; if (bus.fill_level !== 3'd0) begin errors++; $display("FAIL rst_fill: got %0d expected 0", bus.fill_level); end
        #20 reset = 1'b1;
        step();
        checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %0b expected 1", bus.s_ready); end
        checks++; if (bus.countSteps !== 1'b0) begin errors++; $display("FAIL rst_cs_post: got %0b expected 0", bus.countSteps); end
    endtask

    task automatic test_basic();
        xfer_t      x;
        logic [7:0] nxt [2];
        logic [7:0] ea [2];
        logic [7:0] eb [2];
        nxt = '{8'd20, 8'd24};
        ea  = '{8'd14, 8'd18};
        eb  = '{8'd10, 8'd14};
        bus.out_ready = 1'b1;
        push(8'd4); push(8'd8); push(8'd12); push(8'd16);
        checks++; if (bus.countSteps !== 1'b0) begin errors++; $display("FAIL basic_early: countSteps=%0b expected 0", bus.countSteps); end
        step();
        checks++; if (bus.countSteps !== 1'b1 || bus.A !== 8'd10 || bus.B !== 8'd10) begin
            errors++; $display("FAIL basic_first: cs=%0b A=%0d B=%0d expected cs=1 A=10 B=10", bus.countSteps, bus.A, bus.B); end
        step();
        checks++; if (bus.countSteps !== 1'b0 || bus.fill_level !== 3'd0) begin
            errors++; $display("FAIL basic_after: cs=%0b fill=%0d expected 0/0", bus.countSteps, bus.fill_level); end
        for (int k = 0; k < 2; k++) begin
            push(nxt[k]);
            step();
            checks++; if (bus.countSteps !== 1'b1 || bus.A !== ea[k] || bus.B !== eb[k]) begin
                errors++; $display("FAIL basic_run%0d: cs=%0b A=%0d B=%0d expected cs=1 A=%0d B=%0d", k, bus.countSteps, bus.A, bus.B, ea[k], eb[k]); end
            step();
            checks++; if (bus.countSteps !== 1'b0) begin errors++; $display("FAIL basic_pulse%0d: cs=%0b expected 0", k, bus.countSteps); end
        end
        drain();
        while (got_q.size() > 0) begin
            x = got_q.pop_front(); checks++;
            if (x.ea < 0 || x.eb < 0 || x.a !== x.ea[7:0] || x.b !== x.eb[7:0]) begin
                errors++; $display("FAIL basic_pair: A=%0d B=%0d expected A=%0d B=%0d", x.a, x.b, x.ea, x.eb); end
        end
    endtask

    task automatic test_backpressure();
        xfer_t      x;
        logic [7:0] sa, sb;
        do_flush();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) push(8'($urandom_range(0, 255)));
        step();
        checks++; if (bus.countSteps !== 1'b1) begin errors++; $display("FAIL bp_first: cs=%0b expected 1", bus.countSteps); end
        sa = bus.A; sb = bus.B;
        for (int k = 0; k < 4; k++) push(8'($urandom_range(0, 255)));
        bus.s_valid = 1'b1;
        bus.s_data  = 8'($urandom_range(0, 255));
        repeat (3) step();
        checks++; if (bus.fill_level !== 3'd4 || bus.s_ready !== 1'b0) begin
            errors++; $display("FAIL bp_full: fill=%0d s_ready=%0b expected 4/0", bus.fill_level, bus.s_ready); end
        checks++; if (bus.countSteps !== 1'b1 || bus.A !== sa || bus.B !== sb) begin
            errors++; $display("FAIL bp_hold: cs=%0b A=%0d B=%0d expected 1 %0d %0d", bus.countSteps, bus.A, bus.B, sa, sb); end
        bus.s_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 2; k++) push(8'($urandom_range(0, 255)));
        drain();
        checks++; if (n_xfer != 7 || hist.size() != 10) begin
            errors++; $display("FAIL bp_count: transfers=%0d samples=%0d expected 7/10", n_xfer, hist.size()); end
        while (got_q.size() > 0) begin
            x = got_q.pop_front(); checks++;
            if (x.ea < 0 || x.eb < 0 || x.a !== x.ea[7:0] || x.b !== x.eb[7:0]) begin
                errors++; $display("FAIL bp_pair: A=%0d B=%0d expected A=%0d B=%0d", x.a, x.b, x.ea, x.eb); end
        end
    endtask

    task automatic test_saturate();
        xfer_t x;
        do_flush();
        bus.out_ready = 1'b1;
        repeat (4) push(8'd255);
        step();
        checks++; if (bus.countSteps !== 1'b1 || bus.A !== 8'd255 || bus.B !== 8'd255) begin
            errors++; $display("FAIL sat_max: cs=%0b A=%0d B=%0d expected 1 255 255", bus.countSteps, bus.A, bus.B); end
        checks++; if (dut.sum_q !== 10'd1020) begin errors++; $display("FAIL sat_sum: got %0d expected 1020", dut.sum_q); end
        step();
        push(8'd0);
        step();
        checks++; if (bus.countSteps !== 1'b1 || bus.A !== 8'd191 || bus.B !== 8'd255) begin
            errors++; $display("FAIL sat_drop: cs=%0b A=%0d B=%0d expected 1 191 255", bus.countSteps, bus.A, bus.B); end
        drain();
        while (got_q.size() > 0) begin
            x = got_q.pop_front(); checks++;
            if (x.ea < 0 || x.eb < 0 || x.a !== x.ea[7:0] || x.b !== x.eb[7:0]) begin
                errors++; $display("FAIL sat_pair: A=%0d B=%0d expected A=%0d B=%0d", x.a, x.b, x.ea, x.eb); end
        end
    endtask

    task automatic test_flush();
        xfer_t x;
        do_flush();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) push(8'($urandom_range(0, 255)));
        step();
        checks++; if (bus.countSteps !== 1'b1) begin errors++; $display("FAIL fl_emit: cs=%0b expected 1", bus.countSteps); end
        flush = 1'b1; bus.s_valid = 1'b1; bus.s_data = 8'd99; bus.out_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL fl_ready: s_ready=%0b expected 0", bus.s_ready); end
        step();
        flush = 1'b0; bus.s_valid = 1'b0;
        checks++; if (bus.countSteps !== 1'b0 || bus.fill_level !== 3'd0 || bus.A !== 8'd0 || bus.B !== 8'd0) begin
            errors++; $display("FAIL fl_clear: cs=%0b fill=%0d A=%0d B=%0d expected all 0", bus.countSteps, bus.fill_level, bus.A, bus.B); end
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL fl_discard: transfers=%0d expected 0", got_q.size()); end
        for (int k = 0; k < 3; k++) push(8'($urandom_range(0, 255)));
        step(); step();
        checks++; if (bus.countSteps !== 1'b0 || n_xfer != 0) begin
            errors++; $display("FAIL fl_refill: cs=%0b transfers=%0d expected 0/0", bus.countSteps, n_xfer); end
        push(8'($urandom_range(0, 255)));
        step();
        checks++; if (bus.countSteps !== 1'b1) begin errors++; $display("FAIL fl_fourth: cs=%0b expected 1", bus.countSteps); end
        drain();
        checks++; if (n_xfer != 1) begin errors++; $display("FAIL fl_count: transfers=%0d expected 1", n_xfer); end
        while (got_q.size() > 0) begin
            x = got_q.pop_front(); checks++;
            if (x.ea < 0 || x.eb < 0 || x.a !== x.ea[7:0] || x.b !== x.eb[7:0]) begin
                errors++; $display("FAIL fl_pair: A=%0d B=%0d expected A=%0d B=%0d", x.a, x.b, x.ea, x.eb); end
        end
    endtask

    task automatic test_random();
        xfer_t x;
        bit    done;
        done = 1'b0;
        do_flush();
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    push(8'($urandom_range(0, 255)));
                    repeat ($urandom_range(0, 2)) step();
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    bus.out_ready = 1'($urandom_range(0, 1));
                    step();
                end
            end
        join
        drain();
        checks++; if (hist.size() != 40 || n_xfer != 37) begin
            errors++; $display("FAIL rnd_count: samples=%0d transfers=%0d expected 40/37", hist.size(), n_xfer); end
        while (got_q.size() > 0) begin
            x = got_q.pop_front(); checks++;
            if (x.ea < 0 || x.eb < 0 || x.a !== x.ea[7:0] || x.b !== x.eb[7:0]) begin
                errors++; $display("FAIL rnd_pair: A=%0d B=%0d expected A=%0d B=%0d", x.a, x.b, x.ea, x.eb); end
        end
    endtask

    task automatic test_reset_mid();
        xfer_t x;
        do_flush();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) push(8'($urandom_range(1, 255)));
        step();
        #2 reset = 1'b0;
        #1;
        checks++; if (bus.countSteps !== 1'b0 || bus.A !== 8'd0 || bus.B !== 8'd0 || bus.fill_level !== 3'd0) begin
            errors++; $display("FAIL rm_async: cs=%0b A=%0d B=%0d fill=%0d expected all 0", bus.countSteps, bus.A, bus.B, bus.fill_level); end
        #7 reset = 1'b1;
        step();
        checks++; if (bus.s_ready !== 1'b1 || bus.countSteps !== 1'b0) begin
            errors++; $display("FAIL rm_release: s_ready=%0b cs=%0b expected 1/0", bus.s_ready, bus.countSteps); end
        bus.out_ready = 1'b1;
        push(8'd4); push(8'd8); push(8'd12); push(8'd16);
        step();
        checks++; if (bus.countSteps !== 1'b1 || bus.A !== 8'd10 || bus.B !== 8'd10) begin
            errors++; $display("FAIL rm_replay: cs=%0b A=%0d B=%0d expected 1 10 10", bus.countSteps, bus.A, bus.B); end
        drain();
        checks++; if (n_xfer != 1) begin errors++; $display("FAIL rm_count: transfers=%0d expected 1", n_xfer); end
        while (got_q.size() > 0) begin
            x = got_q.pop_front(); checks++;
            if (x.ea < 0 || x.eb < 0 || x.a !== x.ea[7:0] || x.b !== x.eb[7:0]) begin
                errors++; $display("FAIL rm_pair: A=%0d B=%0d expected A=%0d B=%0d", x.a, x.b, x.ea, x.eb); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        bus.s_valid   = 1'b0;
        bus.s_data    = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_saturate();
        test_flush();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
